cpu_step_sequencer: RTL
=======================

// Module: cpu_step_sequencer
// PURPOSE
//  Drives the 6502 single-step handshake for the CPU debugger (100MHz domain). Turns debugger
//  run commands (step, run N, run to breakpoint) into a sequence of o_cpu_step pulses, waiting
//  for each i_cpu_step_completed. Stops on count, breakpoint, halt or timeout and reports the
//  reason. It sits between the debugger value registers and the step/completed sync pair.
// PARAMETERS
//  COUNT_WIDTH     16   width of step count / steps-executed counter
//  TIMEOUT_CYCLES  255  i_clk cycles to wait for i_cpu_step_completed before TIMEOUT (>=1)
// PORTS
//  i_clk                 in   1   100MHz clock
//  i_reset               in   1   synchronous active-high reset
//  i_cmd_valid           in   1   command strobe; accepted only when o_cmd_ready=1
//  i_cmd                 in   2   0=STEP, 1=RUN_N, 2=RUN_TO_BP, 3=reserved (accepted, ignored)
//  i_cmd_count           in   CW  RUN_N: steps; RUN_TO_BP: step limit, 0=unlimited
//  o_cmd_ready           out  1   high in IDLE only
//  i_halt                in   1   level/pulse halt request; ignored in IDLE
//  i_bp_en               in   1   breakpoint enable, sampled at each CHECK
//  i_bp_address          in   16  breakpoint address
//  o_cpu_step            out  1   one-cycle step pulse to 5MHz domain
//  i_cpu_step_completed  in   1   one-cycle completion pulse from 5MHz domain
//  i_cpu_address         in   16  CPU address bus (stable after completion)
//  i_cpu_sync            in   1   CPU opcode-fetch flag
//  o_busy                out  1   high in any state except IDLE
//  o_done                out  1   one-cycle pulse on return to IDLE after an accepted command
//  o_status              out  3   0=NONE 1=COUNT 2=BREAKPOINT 3=HALTED 4=TIMEOUT; held until next accept
//  o_steps               out  CW  steps completed by current/last command
// BEHAVIOUR
//  Reset: state=IDLE; o_cmd_ready=1; o_cpu_step=0; o_busy=0; o_done=0; o_status=0; o_steps=0;
//   halt latch and timeout counter cleared. Reset mid-run abandons the step; late completion ignored.
//  FSM IDLE -> ISSUE -> WAIT -> CHECK -> (ISSUE | IDLE).
//  IDLE: on i_cmd_valid & o_cmd_ready: latch cmd (STEP=RUN_N, count 1) and count;
//   clear o_steps, o_status and halt latch. RUN_N with count 0 -> IDLE next cycle;
//   o_done=1, status COUNT, no step issued. Reserved cmd -> o_done, status NONE.
//  ISSUE: o_cpu_step=1 for exactly this cycle; timeout counter cleared; -> WAIT.
//  WAIT: on i_cpu_step_completed -> o_steps+1, -> CHECK. Timeout counter increments per cycle;
//   reaching TIMEOUT_CYCLES without completion -> IDLE, status TIMEOUT, o_done.
//   Completion and timeout in the same cycle: completion wins.
//  CHECK (one cycle, no step outstanding), priority high->low:
//   1 RUN_TO_BP & i_bp_en & i_cpu_sync & i_cpu_address==i_bp_address -> BREAKPOINT
//   2 halt latch set -> HALTED
//   3 count!=0 & o_steps==count -> COUNT
//   4 o_steps all-ones (saturation, never wraps) -> COUNT
//   else -> ISSUE. A stop leaves via IDLE with o_done pulse.
//  Halt: i_halt in ISSUE/WAIT/CHECK sets latch; an in-flight step is never abandoned.
//   Halt in IDLE has no effect.
//  Latency: command accept to first o_cpu_step = 1 cycle. Completion to next step = 2 cycles.
//  Only one step outstanding at any time; i_cpu_step_completed outside WAIT is ignored.
//  i_cmd_valid while busy is dropped (no queuing).
// TESTING
//  STEP, completion 10 cycles after pulse -> one o_cpu_step; o_done; status=1; o_steps=1.
//  RUN_N count=5, completion 3 cycles after each pulse -> 5 pulses 5 cycles apart; status=1; steps=5.
//  RUN_TO_BP count=0, bp=0x8004 en=1, sync=1 with address 0x8000,0x8002,0x8004 -> stop after 3; status=2.
//  RUN_TO_BP unlimited, i_halt pulse during 4th WAIT -> 4th completes; status=3; steps=4.
//  RUN_N count=3, no completion on 2nd step -> TIMEOUT_CYCLES after pulse: status=4; steps=1; ready=1.
//  i_reset during WAIT of RUN_N=8, then completion pulse -> stays IDLE; all outputs at reset values.

Source files
------------

// File: rtl/cpu_step_sequencer.sv
// Single-step sequencer for the 6502 debugger: turns step/run commands into o_cpu_step
// pulses (one outstanding at a time) and reports why the run stopped.
module cpu_step_sequencer #(
  parameter int unsigned COUNT_WIDTH    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_cmd_valid,
  input  logic [1:0]             i_cmd,
  input  logic [COUNT_WIDTH-1:0] i_cmd_count,
  output logic                   o_cmd_ready,
  input  logic                   i_halt,
  input  logic                   i_bp_en,
  input  logic [15:0]            i_bp_address,
  output logic                   o_cpu_step,
  input  logic                   i_cpu_step_completed,
  input  logic [15:0]            i_cpu_address,
  input  logic                   i_cpu_sync,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [2:0]             o_status,
  output logic [COUNT_WIDTH-1:0] o_steps
);

  localparam int unsigned CW = COUNT_WIDTH;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] CMD_STEP      = 2'd0;
  localparam logic [1:0] CMD_RUN_N     = 2'd1;
  localparam logic [1:0] CMD_RUN_TO_BP = 2'd2;

  localparam logic [2:0] ST_NONE    = 3'd0;
  localparam logic [2:0] ST_COUNT   = 3'd1;
  localparam logic [2:0] ST_BP      = 3'd2;
  localparam logic [2:0] ST_HALTED  = 3'd3;
  localparam logic [2:0] ST_TIMEOUT = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_CHECK} state_e;

  state_e          state_q, state_d;
  logic            run_to_bp_q, run_to_bp_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   steps_q, steps_d;
  logic [2:0]      status_q, status_d;
  logic            halt_q, halt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            step_q, step_d;
  logic            busy_q, busy_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;
  logic            bp_hit_c;
  logic            count_hit_c;

  assign bp_hit_c    = run_to_bp_q && i_bp_en && i_cpu_sync && (i_cpu_address == i_bp_address);
  assign count_hit_c = (count_q != '0) && (steps_q == count_q);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      run_to_bp_q <= 1'b0;
      count_q     <= '0;
      steps_q     <= '0;
      status_q    <= ST_NONE;
      halt_q      <= 1'b0;
      tmo_q       <= '0;
      step_q      <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_to_bp_q <= run_to_bp_d;
      count_q     <= count_d;
      steps_q     <= steps_d;
      status_q    <= status_d;
      halt_q      <= halt_d;
      tmo_q       <= tmo_d;
      step_q      <= step_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
    end
  end

  // Next state; output flops follow the state being entered so they line up with it.
  always_comb begin
    state_d     = state_q;
    run_to_bp_d = run_to_bp_q;
    count_d     = count_q;
    steps_d     = steps_q;
    status_d    = status_q;
    halt_d      = halt_q;
    tmo_d       = tmo_q;
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_cmd_valid && ready_q) begin
          steps_d     = '0;
          status_d    = ST_NONE;
          halt_d      = 1'b0;
          run_to_bp_d = (i_cmd == CMD_RUN_TO_BP);
          count_d     = (i_cmd == CMD_STEP) ? CW'(1) : i_cmd_count;
          unique case (i_cmd)
            CMD_STEP, CMD_RUN_TO_BP: state_d = S_ISSUE;
            CMD_RUN_N: begin
              if (i_cmd_count == '0) begin
                done_d   = 1'b1;
                status_d = ST_COUNT;
              end else begin
                state_d = S_ISSUE;
              end
            end
            default: done_d = 1'b1;
          endcase
        end
      end
      S_ISSUE: begin
        tmo_d   = '0;
        halt_d  = halt_q | i_halt;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        halt_d = halt_q | i_halt;
        // A completion arriving on the last allowed cycle still counts.
        if (i_cpu_step_completed) begin
          if (!(&steps_q)) steps_d = steps_q + CW'(1);
          state_d = S_CHECK;
        end else if (tmo_q == TMO_LAST) begin
          state_d  = S_IDLE;
          status_d = ST_TIMEOUT;
          done_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_CHECK: begin
        halt_d  = halt_q | i_halt;
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (bp_hit_c) begin
          status_d = ST_BP;
        end else if (halt_d) begin
          status_d = ST_HALTED;
        end else if (count_hit_c || (&steps_q)) begin
          status_d = ST_COUNT;
        end else begin
          state_d = S_ISSUE;
          done_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    step_d  = (state_d == S_ISSUE);
    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE);
  end

  assign o_cmd_ready = ready_q;
  assign o_cpu_step  = step_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_status    = status_q;
  assign o_steps     = steps_q;

endmodule
